// File: rtl/mult32x32_arbiter_if.sv
// mult32x32_arbiter_if: request/response channels of both clients plus the multiplier handshake
interface mult32x32_arbiter_if;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic [31:0] req0_a, req0_b;
    logic [63:0] rsp0_product;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [31:0] req1_a, req1_b;
    logic [63:0] rsp1_product;
    logic        mult_start, mult_busy;
    logic [31:0] mult_a, mult_b;
    logic [63:0] mult_product;
    logic        timeout_err;

    modport slave (
        input  req0_valid, req0_a, req0_b, rsp0_ready,
        input  req1_valid, req1_a, req1_b, rsp1_ready,
        input  mult_busy, mult_product,
        output req0_ready, rsp0_valid, rsp0_product,
        output req1_ready, rsp1_valid, rsp1_product,
        output mult_start, mult_a, mult_b, timeout_err
    );

    modport master (
        output req0_valid, req0_a, req0_b, rsp0_ready,
        output req1_valid, req1_a, req1_b, rsp1_ready,
        output mult_busy, mult_product,
        input  req0_ready, rsp0_valid, rsp0_product,
        input  req1_ready, rsp1_valid, rsp1_product,
        input  mult_start, mult_a, mult_b, timeout_err
    );
endinterface

// File: rtl/mult32x32_arbiter.sv
// mult32x32_arbiter: shares one multiplier between two clients, one op in flight (MULT_ARB_ZERO_BYPASS_EN skips it for zero operands)
module mult32x32_arbiter #(
    parameter bit          FIXED_PRIO   = 1'b0,
    parameter int unsigned WAIT_TIMEOUT = 15
) (
    input logic                clk,
    input logic                reset,
    mult32x32_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, START, WAIT_HI, WAIT_LO, SETTLE, RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [63:0] prod_q, prod_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        id_q, id_d, last_q, last_d, err_q, err_d;
    logic        gnt, accept, zero, expired, rsp_ready;
    logic [31:0] sel_a, sel_b;

    // winner selection: a tie goes to the port that did not win last time, or always port 0 when fixed
    always_comb begin
        gnt       = (bus.req0_valid & bus.req1_valid) ? (FIXED_PRIO ? 1'b0 : ~last_q) : bus.req1_valid;
        accept    = (state_q == IDLE) & (bus.req0_valid | bus.req1_valid);
        sel_a     = gnt ? bus.req1_a : bus.req0_a;
        sel_b     = gnt ? bus.req1_b : bus.req0_b;
`ifdef MULT_ARB_ZERO_BYPASS_EN
        zero      = (sel_a == '0) | (sel_b == '0);
`else
        zero      = 1'b0;
`endif
        expired   = cnt_q == 8'(WAIT_TIMEOUT - 1);
        rsp_ready = id_q ? bus.rsp1_ready : bus.rsp0_ready;
    end

    // sequencing of one multiply: start pulse, busy rise/fall, product capture, response hold
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        id_d    = id_q;
        last_d  = last_q;
        err_d   = err_q;
        cnt_d   = (state_q == WAIT_HI || state_q == WAIT_LO) ? cnt_q + 8'd1 : '0;
        case (state_q)
            IDLE: if (accept) begin
                a_d     = sel_a;
                b_d     = sel_b;
                id_d    = gnt;
                last_d  = gnt;
                prod_d  = zero ? '0 : prod_q;
                state_d = zero ? RESP : START;
            end
            START: state_d = WAIT_HI;
            WAIT_HI: if (expired) begin
                prod_d  = '0;
                err_d   = 1'b1;
                state_d = RESP;
            end else if (bus.mult_busy) state_d = WAIT_LO;
            WAIT_LO: if (expired) begin
                prod_d  = '0;
                err_d   = 1'b1;
                state_d = RESP;
            end else if (!bus.mult_busy) state_d = SETTLE;
            SETTLE: begin
                prod_d  = bus.mult_product;
                state_d = RESP;
            end
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers; reset drops any op in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign bus.req0_ready   = accept & ~gnt;
    assign bus.req1_ready   = accept & gnt;
    assign bus.rsp0_valid   = (state_q == RESP) & ~id_q;
    assign bus.rsp1_valid   = (state_q == RESP) & id_q;
    assign bus.rsp0_product = id_q ? '0 : prod_q;
    assign bus.rsp1_product = id_q ? prod_q : '0;
    assign bus.mult_start   = state_q == START;
    assign bus.mult_a       = a_q;
    assign bus.mult_b       = b_q;
    assign bus.timeout_err  = err_q;
endmodule
